// File: rtl/adaptive_thresh_pkg.sv
// adaptive_thresh_pkg
//     Shared types, widths and helper functions for adaptive_thresh_ctrl.
//     - state_t         : controller FSM states
//     - LUMA_W / OFFS_W : luma and offset widths
//     - calc_sum_w / calc_cnt_w : accumulator widths derived from MAX_PIXELS
//     - luma / clamp_thresh     : per-beat luma and 0..1023 saturation
package adaptive_thresh_pkg;

    localparam int unsigned LUMA_W = 10;
    localparam int unsigned OFFS_W = 11;

    typedef enum logic [1:0] {IDLE, DIV, POST} state_t;

    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) n = i + 1;
        end
        return n;
    endfunction

    function automatic int unsigned calc_sum_w(input int unsigned max_pixels);
        return LUMA_W + log2_ceil(max_pixels) + 1;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned max_pixels);
        return log2_ceil(max_pixels) + 1;
    endfunction

    // y = (2r + 5g + b) >> 3, worst case 8184 fits 13 bits, result <= 1023
    function automatic logic [LUMA_W-1:0] luma(input logic [9:0] r,
                                               input logic [9:0] g,
                                               input logic [9:0] b);
        logic [12:0] acc;
        acc = {2'b00, r, 1'b0} + {1'b0, g, 2'b00} + {3'b000, g} + {3'b000, b};
        return acc[12:3];
    endfunction

    function automatic logic [LUMA_W-1:0] clamp_thresh(input logic signed [LUMA_W+1:0] v);
        if (v < 0)
            return '0;
        else if (v > 12'sd1023)
            return '1;
        else
            return v[LUMA_W-1:0];
    endfunction

endpackage

// File: rtl/adaptive_thresh_ctrl_seq_udiv.sv
// seq_udiv
//     Restoring unsigned divider, one quotient bit per cycle (W cycles).
//     start latches dividend/divisor; done pulses for one cycle once
//     quotient is final. Asynchronous active-high reset aborts a divide.
// Ports
//     clk, rst          clock, async active-high reset
//     start             load operands and begin
//     dividend, divisor W-bit operands (divisor must be non-zero)
//     done              1-cycle completion pulse
//     quotient          W-bit result, valid while done is high
module seq_udiv #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W) + 1;

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] step_q;
    logic          run_q;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= '0;
                quo_q  <= dividend;
                dvs_q  <= divisor;
                step_q <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                // dividend bits shift out of quo_q as quotient bits shift in
                if (!trial[W]) begin
                    rem_q <= trial[W-1:0];
                    quo_q <= {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[W-1:0];
                    quo_q <= {quo_q[W-2:0], 1'b0};
                end
                step_q <= step_q + CW'(1);
                if (step_q == CW'(W - 1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/adaptive_thresh_ctrl.sv
// adaptive_thresh_ctrl
//     Passively snoops the RGB AXIS stream, computes the mean luma of each
//     frame and derives the next binarisation threshold for the monocolor
//     stage. thresh_out only changes on an accepted SOF beat.
//     Optional macro ADAPT_THRESH_EMA_EN: smooth the new threshold with a
//     1/4-weight exponential moving average instead of applying it directly.
// Ports
//     clk_in, rst_in         pixel clock, async active-high reset
//     s_tdata_in             r[29:20] b[19:10] g[9:0]
//     s_tvalid_in/s_tready_in/s_tuser_in  snooped handshake, tuser = SOF
//     auto_en_in             1 adaptive, 0 manual_thresh_in
//     offset_in              signed offset added to the mean
//     thresh_out, mean_out   threshold and last frame mean
//     mean_valid_out         pulse on mean_out update
//     busy_out               divide/post-processing in progress
//     drop_out               pulse: SOF arrived while busy, stats discarded
//     ovf_out                sticky frame-size overflow
module adaptive_thresh_ctrl
    import adaptive_thresh_pkg::*;
#(
    parameter int unsigned MAX_PIXELS  = 2097152,
    parameter int unsigned THRESH_INIT = 512
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] s_tdata_in,
    input  logic        s_tvalid_in,
    input  logic        s_tready_in,
    input  logic        s_tuser_in,
    input  logic        auto_en_in,
    input  logic [9:0]  manual_thresh_in,
    input  logic [10:0] offset_in,
    output logic [9:0]  thresh_out,
    output logic [9:0]  mean_out,
    output logic        mean_valid_out,
    output logic        busy_out,
    output logic        drop_out,
    output logic        ovf_out
);

    localparam int unsigned SUM_W = calc_sum_w(MAX_PIXELS);
    localparam int unsigned CNT_W = calc_cnt_w(MAX_PIXELS);

    state_t              state_q, state_d;
    logic [SUM_W-1:0]    sum_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                seen_sof_q;
    logic                frame_ovf_q;
    logic [LUMA_W-1:0]   pend_q;
    logic                pend_vld_q;
    logic                accept, sof;
    logic [LUMA_W-1:0]   y;
    logic                div_start, div_done, drop_d;
    logic [SUM_W-1:0]    quotient;
    logic [SUM_W-1:0]    cnt_ext;
    logic [LUMA_W-1:0]   mean;
    logic signed [LUMA_W+1:0] t_sum;
    logic [LUMA_W-1:0]   t_new;
    logic                unused_bits;
`ifdef ADAPT_THRESH_EMA_EN
    logic signed [LUMA_W+1:0] t_diff;
    logic signed [LUMA_W+1:0] t_ema;
`endif

    assign accept      = s_tvalid_in & s_tready_in;
    assign sof         = accept & s_tuser_in;
    assign y           = luma(s_tdata_in[29:20], s_tdata_in[9:0], s_tdata_in[19:10]);
    assign cnt_ext     = SUM_W'(cnt_q);
    assign mean        = quotient[LUMA_W-1:0];
    assign busy_out    = (state_q != IDLE);
    assign unused_bits = ^{s_tdata_in[31:30], quotient[SUM_W-1:LUMA_W]};

    seq_udiv #(
        .W(SUM_W)
    ) u_div (
        .clk      (clk_in),
        .rst      (rst_in),
        .start    (div_start),
        .dividend (sum_q),
        .divisor  (cnt_ext),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        t_sum = $signed({2'b00, mean}) + $signed({offset_in[OFFS_W-1], offset_in});
`ifdef ADAPT_THRESH_EMA_EN
        t_diff = $signed({2'b00, clamp_thresh(t_sum)}) - $signed({2'b00, pend_q});
        t_ema  = $signed({2'b00, pend_q}) + (t_diff >>> 2);
        t_new  = clamp_thresh(t_ema);
`else
        t_new  = clamp_thresh(t_sum);
`endif
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof && seen_sof_q && !frame_ovf_q) begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                drop_d = sof;
                if (div_done) state_d = POST;
            end
            POST: begin
                drop_d  = sof;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            sum_q          <= '0;
            cnt_q          <= '0;
            seen_sof_q     <= 1'b0;
            frame_ovf_q    <= 1'b0;
            pend_q         <= LUMA_W'(THRESH_INIT);
            pend_vld_q     <= 1'b0;
            thresh_out     <= LUMA_W'(THRESH_INIT);
            mean_out       <= '0;
            mean_valid_out <= 1'b0;
            drop_out       <= 1'b0;
            ovf_out        <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_out       <= drop_d;
            mean_valid_out <= 1'b0;

            if (sof) begin
                if (!auto_en_in)
                    thresh_out <= manual_thresh_in;
                else if (pend_vld_q)
                    thresh_out <= pend_q;
                pend_vld_q  <= 1'b0;
                sum_q       <= SUM_W'(y);
                cnt_q       <= CNT_W'(1);
                seen_sof_q  <= 1'b1;
                frame_ovf_q <= 1'b0;
            end else if (accept) begin
                if (cnt_q == CNT_W'(MAX_PIXELS)) begin
                    ovf_out     <= 1'b1;
                    frame_ovf_q <= 1'b1;
                end else begin
                    sum_q <= sum_q + SUM_W'(y);
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // Placed after the SOF apply so a coincident SOF consumes the old
            // pending value while the fresh one survives for the next SOF.
            if (state_q == POST) begin
                mean_out       <= mean;
                mean_valid_out <= 1'b1;
                pend_q         <= t_new;
                pend_vld_q     <= 1'b1;
            end
        end
    end

endmodule
